// File: rtl/scenario_loader_if.sv
// Request beat channel into the scenario loader: a valid/ready handshake carrying
// a floor index, a passenger word and a commit flag.
interface scenario_loader_if;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_floor;
   logic [5:0] req_value;
   logic       req_last;

   modport master (
      output req_valid, req_floor, req_value, req_last,
      input  req_ready
   );

   modport slave (
      input  req_valid, req_floor, req_value, req_last,
      output req_ready
   );
endinterface

// File: rtl/scenario_loader.sv
// Loads a passenger scenario into the elevator core, pulses its start, then watches the
// returned state for completion or timeout. Optional SCENARIO_LOADER_CLEAR_ON_DONE_EN
// wipes the passenger words on entry to DRAIN.
//
// state | meaning
// IDLE  | accepting request beats, req_ready high
// START | elev_reset_start held high for START_CYCLES cycles
// RUN   | scenario running, elapsed counting, completion/timeout watched
// DRAIN | one-cycle settle (done visible here on completion), then IDLE
module scenario_loader #(
   parameter int TIMEOUT_CYCLES = 200,
   parameter int START_CYCLES   = 2
) (
   input  logic               clock,
   input  logic               reset_start,
   scenario_loader_if.slave   req_bus,
   input  logic [2:0]         cfg_init_1,
   input  logic [2:0]         cfg_init_2,
   output logic [5:0]         passenger_1,
   output logic [5:0]         passenger_2,
   output logic [5:0]         passenger_3,
   output logic [5:0]         passenger_4,
   output logic [5:0]         passenger_5,
   output logic [5:0]         passenger_6,
   output logic [5:0]         passenger_7,
   output logic [2:0]         init_elevator_1,
   output logic [2:0]         init_elevator_2,
   output logic               elev_reset_start,
   input  logic [5:0]         remaining_1,
   input  logic [5:0]         remaining_2,
   input  logic [5:0]         remaining_3,
   input  logic [5:0]         remaining_4,
   input  logic [5:0]         remaining_5,
   input  logic [5:0]         remaining_6,
   input  logic [5:0]         remaining_7,
   input  logic [5:0]         boarding_1,
   input  logic [5:0]         boarding_2,
   output logic               busy,
   output logic               done,
   output logic               timeout,
   output logic [7:0]         elapsed
);

   typedef enum logic [1:0] {IDLE, START, RUN, DRAIN} state_t;

   state_t     state, state_next;
   logic [5:0] passenger [1:7];
   logic [2:0] start_cnt;
   logic [7:0] elapsed_inc;
   logic       transfer, commit, all_zero, run_done, run_timeout, done_next;

   assign transfer    = req_bus.req_valid && (state == IDLE);
   assign commit      = transfer && req_bus.req_last;
   assign all_zero    = ~|{remaining_1, remaining_2, remaining_3, remaining_4, remaining_5,
                           remaining_6, remaining_7, boarding_1, boarding_2};
   assign elapsed_inc = (elapsed == 8'hFF) ? elapsed : elapsed + 8'd1;
   // elapsed is still 0 on the first RUN cycle, which masks the stale all-zero state
   assign run_done    = (state == RUN) && (elapsed != 8'd0) && all_zero;
   assign run_timeout = (state == RUN) && (elapsed_inc == 8'(TIMEOUT_CYCLES));

   always_comb begin
      state_next = state;
      done_next  = 1'b0;
      case (state)
         IDLE:  if (commit) state_next = START;
         START: if (start_cnt == 3'd0) state_next = RUN;
         RUN: begin
            if (run_done) begin
               state_next = DRAIN;
               done_next  = 1'b1;
            end else if (run_timeout) begin
               state_next = DRAIN;
            end
         end
         DRAIN: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset_start) begin
         state           <= IDLE;
         passenger       <= '{default: 6'd0};
         init_elevator_1 <= 3'd0;
         init_elevator_2 <= 3'd0;
         start_cnt       <= 3'd0;
         elapsed         <= 8'd0;
         done            <= 1'b0;
         timeout         <= 1'b0;
      end else begin
         state <= state_next;
         done  <= done_next;
         for (int i = 1; i <= 7; i++) begin
            if (transfer && (req_bus.req_floor == 3'(i))) passenger[i] <= req_bus.req_value;
         end
         if (commit) begin
            init_elevator_1 <= cfg_init_1;
            init_elevator_2 <= cfg_init_2;
            timeout         <= 1'b0;
            elapsed         <= 8'd0;
            start_cnt       <= 3'(START_CYCLES - 1);
         end
         if ((state == START) && (start_cnt != 3'd0)) start_cnt <= start_cnt - 3'd1;
         if (state == RUN) elapsed <= elapsed_inc;
         if (run_timeout && !run_done) timeout <= 1'b1;
`ifdef SCENARIO_LOADER_CLEAR_ON_DONE_EN
         if ((state == RUN) && (state_next == DRAIN)) passenger <= '{default: 6'd0};
`else
`endif
      end
   end

   assign req_bus.req_ready = (state == IDLE);
   assign busy              = (state != IDLE);
   assign elev_reset_start  = (state == START);

   assign passenger_1 = passenger[1];
   assign passenger_2 = passenger[2];
   assign passenger_3 = passenger[3];
   assign passenger_4 = passenger[4];
   assign passenger_5 = passenger[5];
   assign passenger_6 = passenger[6];
   assign passenger_7 = passenger[7];

endmodule

// File: tb/tb_scenario_loader.sv
// Directed bench for scenario_loader: load/start, completion, ignored first RUN cycle,
// floor-0 commit, pending beats, timeout, boarding gating and mid-run reset.
module tb_scenario_loader;
   logic       clock = 1'b0;
   logic       reset_start;
   logic [2:0] cfg_init_1, cfg_init_2;
   logic [5:0] passenger_1, passenger_2, passenger_3, passenger_4, passenger_5,
               passenger_6, passenger_7;
   logic [2:0] init_elevator_1, init_elevator_2;
   logic       elev_reset_start, busy, done, timeout;
   logic [7:0] elapsed;
   logic [5:0] rem [1:7];
   logic [5:0] boarding_1, boarding_2;

   int checks = 0;
   int passes = 0;
   int done_seen = 0;
   int done_ref;

`ifdef SCENARIO_LOADER_CLEAR_ON_DONE_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif

   scenario_loader_if bus ();

   scenario_loader #(.TIMEOUT_CYCLES(20), .START_CYCLES(2)) dut (
      .clock(clock), .reset_start(reset_start), .req_bus(bus.slave),
      .cfg_init_1(cfg_init_1), .cfg_init_2(cfg_init_2),
      .passenger_1(passenger_1), .passenger_2(passenger_2), .passenger_3(passenger_3),
      .passenger_4(passenger_4), .passenger_5(passenger_5), .passenger_6(passenger_6),
      .passenger_7(passenger_7),
      .init_elevator_1(init_elevator_1), .init_elevator_2(init_elevator_2),
      .elev_reset_start(elev_reset_start),
      .remaining_1(rem[1]), .remaining_2(rem[2]), .remaining_3(rem[3]), .remaining_4(rem[4]),
      .remaining_5(rem[5]), .remaining_6(rem[6]), .remaining_7(rem[7]),
      .boarding_1(boarding_1), .boarding_2(boarding_2),
      .busy(busy), .done(done), .timeout(timeout), .elapsed(elapsed)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (done === 1'b1) done_seen++;

   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic beat(logic v, logic [2:0] f, logic [5:0] val, logic l);
      bus.req_valid = v;
      bus.req_floor = f;
      bus.req_value = val;
      bus.req_last  = l;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_start = 1'b1;
      cfg_init_1 = 3'd0;
      cfg_init_2 = 3'd0;
      for (int i = 1; i <= 7; i++) rem[i] = 6'd0;
      boarding_1 = 6'd0;
      boarding_2 = 6'd0;
      beat(1'b0, 3'd0, 6'd0, 1'b0);
      tick(2);
      reset_start = 1'b0;

      chk("rst_ready", bus.req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_pass", {passenger_1, passenger_3, passenger_7}, 0);
      chk("rst_misc", {done, timeout, elev_reset_start, elapsed}, 0);

      // load and start, completion on RUN cycle 10
      rem[1] = 6'd1;
      beat(1'b1, 3'd3, 6'h05, 1'b0);
      tick();
      chk("p3_write", passenger_3, 6'h05);
      chk("still_idle", bus.req_ready, 1);
      cfg_init_1 = 3'd1;
      cfg_init_2 = 3'd4;
      beat(1'b1, 3'd7, 6'h21, 1'b1);
      tick();
      beat(1'b0, 3'd0, 6'd0, 1'b0);
      cfg_init_1 = 3'd6;
      cfg_init_2 = 3'd6;
      chk("p7_write", passenger_7, 6'h21);
      chk("p3_keep", passenger_3, 6'h05);
      chk("others_zero", {passenger_1, passenger_2, passenger_4, passenger_5, passenger_6}, 0);
      chk("init_latch", {init_elevator_1, init_elevator_2}, {3'd1, 3'd4});
      chk("start1_pulse", elev_reset_start, 1);
      chk("start1_busy", {busy, bus.req_ready}, 2'b10);
      tick();
      chk("start2_pulse", elev_reset_start, 1);
      tick();
      chk("run_pulse_low", elev_reset_start, 0);
      chk("run1_elapsed", elapsed, 0);
      tick(9);
      chk("run10_elapsed", elapsed, 9);
      chk("run10_nodone", done_seen, 0);
      chk("init_stable", {init_elevator_1, init_elevator_2}, {3'd1, 3'd4});
      rem[1] = 6'd0;
      tick();
      chk("drain_done", done, 1);
      chk("drain_elapsed", elapsed, 10);
      chk("drain_flags", {timeout, busy, bus.req_ready}, 3'b010);
      tick();
      chk("idle_after_done", {done, busy, bus.req_ready}, 3'b001);
      chk("done_once", done_seen, 1);
      chk("p3_after_drain", passenger_3, CLR ? 6'h00 : 6'h05);
      chk("p7_after_drain", passenger_7, CLR ? 6'h00 : 6'h21);

      // floor 0 commit, first RUN cycle ignored, beat held during busy stays pending
      beat(1'b1, 3'd0, 6'h3F, 1'b1);
      tick();
      chk("f0_start", elev_reset_start, 1);
      chk("f0_p3", passenger_3, CLR ? 6'h00 : 6'h05);
      chk("f0_p7", passenger_7, CLR ? 6'h00 : 6'h21);
      chk("f0_p1", passenger_1, 0);
      beat(1'b1, 3'd1, 6'h2A, 1'b1);
      tick(2);
      chk("held_ready", bus.req_ready, 0);
      chk("held_p1", passenger_1, 0);
      tick();
      chk("first_run_ignored", {done, elapsed}, {1'b0, 8'd1});
      tick();
      chk("f0_done", {done, elapsed}, {1'b1, 8'd2});
      chk("held_p1_drain", passenger_1, 0);
      tick();
      chk("held_idle", {bus.req_ready, passenger_1}, {1'b1, 6'h00});
      tick();
      beat(1'b0, 3'd0, 6'd0, 1'b0);
      chk("pending_xfer", {passenger_1, elev_reset_start}, {6'h2A, 1'b1});
      tick(4);
      chk("pending_done", done, 1);
      tick();
      chk("p1_after_drain", passenger_1, CLR ? 6'h00 : 6'h2A);

      // timeout with state never zero
      rem[2] = 6'd3;
      cfg_init_1 = 3'd2;
      cfg_init_2 = 3'd6;
      done_ref = done_seen;
      beat(1'b1, 3'd5, 6'h11, 1'b1);
      tick();
      beat(1'b0, 3'd0, 6'd0, 1'b0);
      tick(2);
      tick(19);
      chk("to_before", {timeout, elapsed}, {1'b0, 8'd19});
      tick();
      chk("to_set", {timeout, elapsed, done, busy}, {1'b1, 8'd20, 1'b0, 1'b1});
      tick();
      chk("to_sticky", {timeout, bus.req_ready}, 2'b11);
      chk("to_no_done", done_seen, done_ref);
      chk("to_p5", passenger_5, CLR ? 6'h00 : 6'h11);
      chk("to_init", {init_elevator_1, init_elevator_2}, {3'd2, 3'd6});

      // next commit clears timeout; boarding alone blocks completion
      rem[2] = 6'd0;
      boarding_2 = 6'd1;
      cfg_init_1 = 3'd3;
      cfg_init_2 = 3'd5;
      beat(1'b1, 3'd0, 6'h00, 1'b1);
      tick();
      beat(1'b0, 3'd0, 6'd0, 1'b0);
      chk("to_clear", {timeout, elapsed}, {1'b0, 8'd0});
      chk("init_relatch", {init_elevator_1, init_elevator_2}, {3'd3, 3'd5});
      tick(2);
      tick(3);
      chk("boarding_blocks", {done, busy, elapsed}, {1'b0, 1'b1, 8'd3});
      boarding_2 = 6'd0;
      tick();
      chk("boarding_done", {done, elapsed}, {1'b1, 8'd4});
      tick();

      // reset on RUN cycle 5 aborts with no done
      rem[4] = 6'd7;
      cfg_init_1 = 3'd7;
      cfg_init_2 = 3'd7;
      beat(1'b1, 3'd2, 6'h0C, 1'b1);
      tick();
      beat(1'b0, 3'd0, 6'd0, 1'b0);
      tick(2);
      tick(4);
      chk("run5_elapsed", {elapsed, passenger_2}, {8'd4, 6'h0C});
      done_ref = done_seen;
      reset_start = 1'b1;
      tick();
      reset_start = 1'b0;
      chk("abort_pass", {passenger_1, passenger_2, passenger_3, passenger_5, passenger_7}, 0);
      chk("abort_init", {init_elevator_1, init_elevator_2}, 0);
      chk("abort_misc", {elapsed, done, timeout, busy, elev_reset_start}, 0);
      chk("abort_ready", bus.req_ready, 1);
      tick(3);
      chk("abort_no_done", done_seen, done_ref);
      chk("abort_idle", {busy, bus.req_ready}, 2'b01);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/scenario_loader.md
SCENARIO_LOADER -- requirements
Module: scenario_loader

Interface
REQ-001 The block SHALL use parameter TIMEOUT_CYCLES, default 200, as the maximum RUN cycles before a timeout is declared (legal range 1..255).
REQ-002 The block SHALL use parameter START_CYCLES, default 2, as the width in cycles of the elevator start pulse (legal range 1..7).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high (clock, reset_start).
REQ-004 Ports SHALL be as follows:
- clock  in  1  system clock.
- reset_start  in  1  synchronous active-high reset.
- req_valid  in  1  request beat valid.
- req_ready  out  1  loader accepts a beat.
- req_floor  in  3  target floor 1..7.
- req_value  in  6  passenger word for that floor.
- req_last  in  1  beat commits the scenario.
- cfg_init_1, cfg_init_2  in  3 each  elevator start floors.
- passenger_1..passenger_7  out  6 each  scenario words to the elevator core.
- init_elevator_1, init_elevator_2  out  3 each  latched start floors.
- elev_reset_start  out  1  start/reset pulse to the elevator core.
- remaining_1..remaining_7  in  6 each  returned per-floor waiting state.
- boarding_1, boarding_2  in  6 each  returned car occupancy.
- busy  out  1  scenario in progress.
- done  out  1  one-cycle completion pulse.
- timeout  out  1  sticky timeout flag.
- elapsed  out  8  RUN cycles of the last scenario.

Function
REQ-005 The FSM SHALL have exactly the states IDLE, START, RUN and DRAIN.
REQ-006 req_ready SHALL be 1 only in IDLE; a beat transfers when req_valid and req_ready are both 1 in the same cycle.
REQ-007 On a transfer with req_floor in 1..7, the value SHALL be written to passenger_<req_floor> on the next clock edge, and a later write to the same floor SHALL overwrite it.
REQ-008 On a transfer with req_floor 0, the value SHALL be discarded, and req_last on that beat SHALL still commit.
REQ-009 A transfer with req_last=1 SHALL store its value, latch cfg_init_1/2 into init_elevator_1/2, clear timeout and elapsed, and move to START, all on the same edge.
REQ-010 In START, elev_reset_start SHALL be 1 for exactly START_CYCLES consecutive cycles, then the FSM SHALL enter RUN; elev_reset_start SHALL be 0 in every other state.
REQ-011 In RUN, elapsed SHALL increment by 1 per cycle and saturate at 255.
REQ-012 In RUN, the FSM SHALL ignore the first cycle, so an all-zero returned state is never sampled on the pulse edge.
REQ-013 From the second RUN cycle, when all remaining_1..7 and boarding_1/2 equal 0, the FSM SHALL pulse done=1 for one cycle and go to DRAIN.
REQ-014 When elapsed reaches TIMEOUT_CYCLES in RUN, timeout SHALL be set to 1 and the FSM SHALL go to DRAIN with no done pulse.
REQ-015 If completion and timeout are detected in the same cycle, completion SHALL win: done=1, timeout stays 0.
REQ-016 DRAIN SHALL last one cycle and then return to IDLE.
REQ-017 busy SHALL be 1 in START, RUN and DRAIN.
REQ-018 passenger_* and init_elevator_* SHALL remain stable from START through DRAIN.
REQ-019 req_valid asserted outside IDLE SHALL have no effect, and the beat SHALL stay pending until IDLE.

Reset
REQ-020 On reset_start=1 at a clock edge, the FSM SHALL go to IDLE, regardless of the current state.
REQ-021 On that reset edge, all passenger_*, init_elevator_*, elapsed, done, timeout, busy and elev_reset_start SHALL be set to 0.
REQ-022 After that reset edge, req_ready SHALL be 1.
REQ-023 A reset during START or RUN SHALL abort the scenario with no done pulse.

Configuration
REQ-024 With macro SCENARIO_LOADER_CLEAR_ON_DONE_EN defined, the FSM SHALL clear all passenger_* registers to 0 on entry to DRAIN.
REQ-025 Without SCENARIO_LOADER_CLEAR_ON_DONE_EN defined, passenger_* SHALL hold their values until overwritten or reset.

Verification
REQ-026 Test: write floor3=6'h05, then floor7=6'h21 with req_last, cfg_init=1/4 -> passenger_3=05, passenger_7=21, others 0, init=1/4, elev_reset_start high for 2 cycles, busy=1.
REQ-027 Test: returned state goes all-zero on RUN cycle 10 -> done pulses once, elapsed=10, timeout=0, req_ready=1 two cycles later.
REQ-028 Test: returned state never zero, TIMEOUT_CYCLES=20 -> timeout=1 and elapsed=20 with no done pulse; timeout clears on the next committed scenario.
REQ-029 Test: req_floor=0 with req_last and req_value=3F -> no passenger register changes and START is entered; req_valid held during RUN -> no transfer.
REQ-030 Test: reset_start on RUN cycle 5 -> all outputs 0 next cycle, no done, req_ready=1.
REQ-031 Test: run the completion scenario of REQ-027 once with SCENARIO_LOADER_CLEAR_ON_DONE_EN defined and once without -> passenger_* is 0 after DRAIN when defined and retains its values when not defined.
